mmc3_irq_unit: RTL and testbench
================================

# mmc3_irq_unit

MMC3-style scanline IRQ unit for the mapper family. It samples PPU A12 and M2 on the fast system clock and filters A12 rises by counting M2 low-time. It runs the 8-bit reload/decrement counter and drives the cartridge IRQ line. It sits downstream of the mapper's CPU register decoder, which delivers $C000/$C001/$E000/$E001 writes as one-cycle strobes, and upstream of the IRQ output mux in map_out.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth for ppu_a12 and m2 (minimum 2).
- FILTER_M2, 3, number of M2 falling edges A12 must stay low before a rise counts (1..7).

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- map_rst  in  1  synchronous mapper reset (active-high); same effect as rst_n, applied on a clk edge.
- m2  in  1  CPU M2, asynchronous to clk.
- ppu_a12  in  1  PPU address bit 12, asynchronous to clk.
- reg_we  in  1  one-clk write strobe from the register decoder.
- reg_sel  in  2  0=latch ($C000), 1=reload ($C001), 2=disable/ack ($E000), 3=enable ($E001).
- reg_dat  in  8  write data, used for latch only.
- mmc3b_mode  in  1  0=Rev A IRQ rule, 1=Rev B IRQ rule.
- irq  out  1  IRQ request, active-high, registered.
- irq_ctr  out  8  current counter value, for save-state readout.
- a12_clk  out  1  one-clk pulse per accepted A12 rise (debug/observe).

## Operation
- Synchronize m2 and ppu_a12 through SYNC_STAGES flops. Keep one extra delayed copy of each for edge detection.
- Filter FSM, states HIGH, LOW, ARMED:
  - HIGH: A12 is high. On A12 low, go to LOW with low_cnt=0.
  - LOW: each M2 falling edge increments low_cnt. When low_cnt reaches FILTER_M2, go to ARMED. An A12 rise while in LOW goes to HIGH with no event.
  - ARMED: an A12 rise pulses a12_clk and goes to HIGH.
  - low_cnt is 3 bits wide and saturates.
- Counter update on a12_clk:
  - If ctr==0 or reload_req: ctr<=latch, reload_req<=0.
  - Else: ctr<=ctr-1.
- IRQ set rule, evaluated on the post-update value; only when irq_en=1:
  - Rev B (mmc3b_mode=1): new ctr==0 sets irq_pend.
  - Rev A (mmc3b_mode=0): new ctr==0 sets irq_pend only if the old ctr was nonzero or reload_req was set.
- Register writes:
  - sel0: latch<=reg_dat.
  - sel1: ctr<=0 and reload_req<=1.
  - sel2: irq_en<=0 and irq_pend<=0.
  - sel3: irq_en<=1.
- irq = irq_pend (registered).
- Simultaneous register write and a12_clk in the same cycle:
  - The counter update uses the pre-write latch, ctr and reload_req.
  - A sel1 write then overrides the result: ctr=0, reload_req=1.
  - A sel2 write wins over an IRQ set: pend ends at 0.
  - A sel3 write does not enable a set in that same cycle.
- Reset values (rst_n low or map_rst): ctr=0, latch=0, reload_req=0, irq_en=0, irq_pend=0, FSM=HIGH, low_cnt=0, irq=0, a12_clk=0, sync flops=0.
- Reset mid-filter discards the partial low count. The first A12 rise after reset never counts unless it was preceded by FILTER_M2 M2 falls.

## Timing
- Pin edge to synchronized signal: SYNC_STAGES clk edges.
- a12_clk is high for exactly 1 clk, on the cycle after the synchronized rise is detected.
- ctr and irq_pend update on that same edge, so irq rises SYNC_STAGES+1 clk edges after ppu_a12 rises at the pin.
- A register write takes effect on the clk edge where reg_we=1. irq falls on that edge for sel2.
- Two M2 falls closer than 2 clk apart are outside the spec (clk ≥ 8× M2 frequency).

## Structure
- Shared package mmc3_pkg:
  - reg_sel encodings REG_LATCH/REG_RELOAD/REG_IRQ_OFF/REG_IRQ_ON.
  - Filter FSM state enum.
  - FILTER_M2 default.
- One sub-module, mmc3_a12_filter: synchronizers plus the filter FSM, producing a12_clk. The counter and IRQ logic stay in the top module.

## Test plan
- Latch=5, sel1, enable. Apply 6 filtered A12 rises (4 M2 falls low each). ctr goes 5,4,3,2,1,0; irq rises on the 6th rise, SYNC_STAGES+1 clk after the pin edge.
- A12 pulses separated by only 2 M2 falls (FILTER_M2=3) -> no a12_clk, ctr unchanged.
- Latch=0, Rev A, enabled, ctr=0, no reload_req, one rise -> ctr=0, irq stays 0. Same setup with Rev B -> irq=1.
- irq pending, then a sel2 write in the same cycle as an a12_clk that would reach 0 -> irq=0, irq_en=0.
- sel1 write in the same cycle as an a12_clk with ctr=3 -> ctr=0, reload_req=1. The next rise loads the latch.
- rst_n pulsed low mid-LOW state with irq=1 -> irq, ctr and latch all 0 asynchronously. The next single rise produces no a12_clk.

Source files
------------

// File: rtl/mmc3_pkg.sv
// mmc3 shared types: register select codes,
// A12 filter states and the IRQ register bundle.
package mmc3_pkg;

  localparam logic [1:0] REG_LATCH   = 2'd0;
  localparam logic [1:0] REG_RELOAD  = 2'd1;
  localparam logic [1:0] REG_IRQ_OFF = 2'd2;
  localparam logic [1:0] REG_IRQ_ON  = 2'd3;

  localparam int FILTER_M2_DEF = 3;

  typedef enum logic [1:0] {
    F_HIGH,
    F_LOW,
    F_ARMED
  } filt_state_t;

  typedef struct packed {
    logic [7:0] ctr;
    logic [7:0] latch;
    logic       reload;
    logic       en;
    logic       pend;
  } irq_regs_t;

endpackage

// File: rtl/mmc3_a12_filter.sv
// mmc3 A12 filter: synchronizers and M2 low-time
// qualifier producing one event per accepted rise.
module mmc3_a12_filter
  import mmc3_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_M2   = FILTER_M2_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic map_rst,
  input  logic m2,
  input  logic ppu_a12,
  output logic a12_evt,
  output logic a12_clk
);

  localparam logic [2:0] FILT_N = 3'(FILTER_M2);

  logic [SYNC_STAGES-1:0] a12_sync;
  logic [SYNC_STAGES-1:0] m2_sync;
  logic                   a12_d;
  logic                   m2_d;
  logic                   a12_s;
  logic                   m2_s;
  logic                   a12_rise;
  logic                   m2_fall;
  logic [2:0]             low_cnt;
  logic [2:0]             cnt_inc;
  filt_state_t            state;

  assign a12_s    = a12_sync[SYNC_STAGES-1];
  assign m2_s     = m2_sync[SYNC_STAGES-1];
  assign a12_rise = a12_s & ~a12_d;
  assign m2_fall  = m2_d & ~m2_s;
  assign cnt_inc  = (low_cnt == 3'h7) ?
                    low_cnt : low_cnt + 3'd1;
  assign a12_evt  = (state == F_ARMED) & a12_rise;

  // Synchronizer chains plus one delayed copy each
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a12_sync <= '0;
      m2_sync  <= '0;
      a12_d    <= 1'b0;
      m2_d     <= 1'b0;
    end else if (map_rst) begin
      a12_sync <= '0;
      m2_sync  <= '0;
      a12_d    <= 1'b0;
      m2_d     <= 1'b0;
    end else begin
      a12_sync <= {a12_sync[SYNC_STAGES-2:0], ppu_a12};
      m2_sync  <= {m2_sync[SYNC_STAGES-2:0], m2};
      a12_d    <= a12_s;
      m2_d     <= m2_s;
    end
  end

  // Filter FSM: A12 must sit low for FILTER_M2 M2 falls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= F_HIGH;
      low_cnt <= 3'd0;
      a12_clk <= 1'b0;
    end else if (map_rst) begin
      state   <= F_HIGH;
      low_cnt <= 3'd0;
      a12_clk <= 1'b0;
    end else begin
      a12_clk <= a12_evt;
      unique case (state)
        F_HIGH: begin
          if (!a12_s) begin
            state   <= F_LOW;
            low_cnt <= 3'd0;
          end
        end
        F_LOW: begin
          if (a12_rise) begin
            state <= F_HIGH;
          end else if (m2_fall) begin
            low_cnt <= cnt_inc;
            if (cnt_inc >= FILT_N)
              state <= F_ARMED;
          end
        end
        F_ARMED: begin
          if (a12_rise)
            state <= F_HIGH;
        end
        default: state <= F_HIGH;
      endcase
    end
  end

endmodule

// File: rtl/mmc3_irq_unit.sv
// mmc3 scanline IRQ: reload/decrement counter,
// register writes and the cartridge IRQ line.
module mmc3_irq_unit
  import mmc3_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_M2   = FILTER_M2_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       map_rst,
  input  logic       m2,
  input  logic       ppu_a12,
  input  logic       reg_we,
  input  logic [1:0] reg_sel,
  input  logic [7:0] reg_dat,
  input  logic       mmc3b_mode,
  output logic       irq,
  output logic [7:0] irq_ctr,
  output logic       a12_clk
);

  irq_regs_t r;
  irq_regs_t r_n;
  logic      a12_evt;
  logic      irq_set;

  mmc3_a12_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_M2  (FILTER_M2)
  ) u_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .map_rst(map_rst),
    .m2     (m2),
    .ppu_a12(ppu_a12),
    .a12_evt(a12_evt),
    .a12_clk(a12_clk)
  );

  // Counter step on pre-write state, then writes override
  always_comb begin
    r_n = r;
    if (a12_evt) begin
      if (r.ctr == 8'd0 || r.reload) begin
        r_n.ctr    = r.latch;
        r_n.reload = 1'b0;
      end else begin
        r_n.ctr = r.ctr - 8'd1;
      end
    end
    irq_set = a12_evt && r.en &&
              (r_n.ctr == 8'd0) &&
              (mmc3b_mode || r.ctr != 8'd0 ||
               r.reload);
    if (irq_set)
      r_n.pend = 1'b1;
    if (reg_we) begin
      unique case (reg_sel)
        REG_LATCH: r_n.latch = reg_dat;
        REG_RELOAD: begin
          r_n.ctr    = 8'd0;
          r_n.reload = 1'b1;
        end
        REG_IRQ_OFF: begin
          r_n.en   = 1'b0;
          r_n.pend = 1'b0;
        end
        REG_IRQ_ON: r_n.en = 1'b1;
        default: ;
      endcase
    end
  end

  // IRQ register bundle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r <= '0;
    else if (map_rst)
      r <= '0;
    else
      r <= r_n;
  end

  assign irq     = r.pend;
  assign irq_ctr = r.ctr;

endmodule

// File: tb/tb_mmc3_irq_unit.sv
// Bench for mmc3_irq_unit: vector table plus
// hand sequences for same-cycle and reset cases.
module tb_mmc3_irq_unit;

  localparam int SYNC = 2;
  localparam int EVT_TICK = SYNC + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       map_rst = 1'b0;
  logic       m2 = 1'b0;
  logic       ppu_a12 = 1'b0;
  logic       reg_we = 1'b0;
  logic [1:0] reg_sel = 2'd0;
  logic [7:0] reg_dat = 8'd0;
  logic       mmc3b_mode = 1'b0;
  logic       irq;
  logic [7:0] irq_ctr;
  logic       a12_clk;

  int n_pass = 0;
  int n_tot = 0;
  logic irq_pre;

  mmc3_irq_unit #(
    .SYNC_STAGES(SYNC),
    .FILTER_M2  (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .map_rst   (map_rst),
    .m2        (m2),
    .ppu_a12   (ppu_a12),
    .reg_we    (reg_we),
    .reg_sel   (reg_sel),
    .reg_dat   (reg_dat),
    .mmc3b_mode(mmc3b_mode),
    .irq       (irq),
    .irq_ctr   (irq_ctr),
    .a12_clk   (a12_clk)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_pulse;
    logic [1:0] sel;
    logic [7:0] dat;
    int         nf;
    bit         mode;
    int         ectr;
    int         eirq;
    int         epulse;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    n_tot++;
    if (act == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] s,
                    input logic [7:0] d);
    reg_we  = 1'b1;
    reg_sel = s;
    reg_dat = d;
    tick();
    reg_we = 1'b0;
  endtask

  task automatic m2_falls(input int n);
    repeat (n) begin
      m2 = 1'b1;
      repeat (4) tick();
      m2 = 1'b0;
      repeat (4) tick();
    end
  endtask

  task automatic pulse(input int nf,
                       input bit dw,
                       input logic [1:0] ws,
                       input logic [7:0] wd,
                       output int np,
                       output int ft);
    ppu_a12 = 1'b0;
    repeat (4) tick();
    m2_falls(nf);
    ppu_a12 = 1'b1;
    np = 0;
    ft = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i == EVT_TICK && dw) begin
        reg_we  = 1'b1;
        reg_sel = ws;
        reg_dat = wd;
      end
      tick();
      reg_we = 1'b0;
      if (i == EVT_TICK - 1)
        irq_pre = irq;
      if (a12_clk) begin
        np++;
        if (ft == 0)
          ft = i;
      end
    end
  endtask

  task automatic rise(input int nf,
                      output int np);
    int ft;
    pulse(nf, 1'b0, 2'd0, 8'd0, np, ft);
  endtask

  initial begin
    int np;
    int ft;

    vt[0]  = '{0, 2'd0, 8'd5, 0, 0, 0, 0, 0};
    vt[1]  = '{0, 2'd1, 8'd0, 0, 0, 0, 0, 0};
    vt[2]  = '{0, 2'd3, 8'd0, 0, 0, 0, 0, 0};
    vt[3]  = '{1, 2'd0, 8'd0, 4, 0, 5, 0, 1};
    vt[4]  = '{1, 2'd0, 8'd0, 4, 0, 4, 0, 1};
    vt[5]  = '{1, 2'd0, 8'd0, 4, 0, 3, 0, 1};
    vt[6]  = '{1, 2'd0, 8'd0, 4, 0, 2, 0, 1};
    vt[7]  = '{1, 2'd0, 8'd0, 4, 0, 1, 0, 1};
    vt[8]  = '{1, 2'd0, 8'd0, 4, 0, 0, 1, 1};
    vt[9]  = '{1, 2'd0, 8'd0, 2, 0, 0, 1, 0};
    vt[10] = '{0, 2'd2, 8'd0, 0, 0, 0, 0, 0};
    vt[11] = '{0, 2'd0, 8'd0, 0, 0, 0, 0, 0};
    vt[12] = '{0, 2'd3, 8'd0, 0, 0, 0, 0, 0};
    vt[13] = '{1, 2'd0, 8'd0, 4, 0, 0, 0, 1};
    vt[14] = '{1, 2'd0, 8'd0, 4, 1, 0, 1, 1};
    vt[15] = '{0, 2'd2, 8'd0, 0, 1, 0, 0, 0};

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_irq", irq, 0);
    chk("rst_ctr", irq_ctr, 0);
    chk("rst_a12clk", a12_clk, 0);

    for (int i = 0; i < 16; i++) begin
      mmc3b_mode = vt[i].mode;
      if (vt[i].is_pulse) begin
        pulse(vt[i].nf, 1'b0, 2'd0, 8'd0,
              np, ft);
        chk($sformatf("v%0d_pulses", i),
            np, vt[i].epulse);
        if (vt[i].epulse == 1)
          chk($sformatf("v%0d_tick", i),
              ft, EVT_TICK);
        if (i == 8)
          chk("v8_irq_pre", irq_pre, 0);
      end else begin
        wr(vt[i].sel, vt[i].dat);
      end
      chk($sformatf("v%0d_ctr", i),
          irq_ctr, vt[i].ectr);
      chk($sformatf("v%0d_irq", i),
          irq, vt[i].eirq);
    end

    // sel2 on the same edge as a reaching-zero step
    mmc3b_mode = 1'b0;
    wr(2'd0, 8'd1);
    wr(2'd1, 8'd0);
    wr(2'd3, 8'd0);
    rise(4, np);
    chk("a_ctr1", irq_ctr, 1);
    rise(4, np);
    chk("a_irq_set", irq, 1);
    rise(4, np);
    chk("a_ctr_reload", irq_ctr, 1);
    chk("a_irq_hold", irq, 1);
    pulse(4, 1'b1, 2'd2, 8'd0, np, ft);
    chk("a_off_pulses", np, 1);
    chk("a_off_ctr", irq_ctr, 0);
    chk("a_off_irq", irq, 0);
    rise(4, np);
    rise(4, np);
    chk("a_dis_ctr", irq_ctr, 0);
    chk("a_dis_irq", irq, 0);

    // sel1 on the same edge as a decrement from 3
    wr(2'd0, 8'd3);
    wr(2'd1, 8'd0);
    rise(4, np);
    chk("b_ctr3", irq_ctr, 3);
    wr(2'd0, 8'd6);
    pulse(4, 1'b1, 2'd1, 8'd0, np, ft);
    chk("b_rl_pulses", np, 1);
    chk("b_rl_ctr", irq_ctr, 0);
    rise(4, np);
    chk("b_load_ctr", irq_ctr, 6);

    // async reset in the middle of a low count
    wr(2'd0, 8'd0);
    wr(2'd1, 8'd0);
    wr(2'd3, 8'd0);
    mmc3b_mode = 1'b1;
    rise(4, np);
    chk("c_irq_set", irq, 1);
    wr(2'd0, 8'd9);
    ppu_a12 = 1'b0;
    repeat (4) tick();
    m2_falls(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("c_async_irq", irq, 0);
    chk("c_async_ctr", irq_ctr, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    ppu_a12 = 1'b1;
    np = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (a12_clk)
        np++;
    end
    chk("c_first_rise", np, 0);
    wr(2'd1, 8'd0);
    rise(4, np);
    chk("c_rise_ok", np, 1);
    chk("c_latch_clr", irq_ctr, 0);
    chk("c_en_clr", irq, 0);

    // synchronous mapper reset
    wr(2'd0, 8'd4);
    wr(2'd1, 8'd0);
    rise(4, np);
    chk("d_ctr4", irq_ctr, 4);
    map_rst = 1'b1;
    tick();
    map_rst = 1'b0;
    chk("d_maprst_ctr", irq_ctr, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
